// File: rtl/instr_encode_loader.sv
// Instruction encoder and loader.
// Encodes symbolic ops into MIPS words, buffers them and writes them to imem.
module instr_encode_loader #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              finish,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [3:0]        op_kind,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [15:0]       imm,
    input  logic [25:0]       target,
    output logic              mem_we,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   word_count,
    output logic              illegal_err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [3:0] K_ADD = 4'd0;
    localparam logic [3:0] K_SUB = 4'd1;
    localparam logic [3:0] K_AND = 4'd2;
    localparam logic [3:0] K_OR  = 4'd3;
    localparam logic [3:0] K_SLT = 4'd4;
    localparam logic [3:0] K_LW  = 4'd5;
    localparam logic [3:0] K_SW  = 4'd6;
    localparam logic [3:0] K_J   = 4'd7;
    localparam logic [3:0] K_BEQ = 4'd8;
    localparam logic [3:0] K_BNE = 4'd9;
    localparam logic [3:0] K_NOP = 4'd10;

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0] CNT_FULL = (PW + 1)'(DEPTH);
    localparam logic [ADDR_W:0] SPAN = {1'b1, {ADDR_W{1'b0}}};

    logic [1:0]        state;
    logic [31:0]       fifo [DEPTH];
    logic [PW-1:0]     wptr;
    logic [PW-1:0]     rptr;
    logic [PW:0]       cnt;
    logic              full;
    logic [ADDR_W-1:0] base_lat;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   acc;
    logic [ADDR_W:0]   limit;
    logic [ADDR_W:0]   wc;
    logic              ill_q;
    logic              legal;
    logic [31:0]       enc;
    logic              active;
    logic              accept;
    logic              push;
    logic              pop;
    logic              sess_go;

    assign active   = (state == S_LOAD) || (state == S_DRAIN);
    assign full     = (cnt == CNT_FULL);
    // Words still allowed before the address space would wrap.
    assign limit    = SPAN - {1'b0, base_lat};
    assign op_ready = (state == S_LOAD) && !full && (acc < limit);
    assign accept   = op_valid && op_ready;
    assign push     = accept && legal;
    assign mem_we   = active && (cnt != '0);
    assign pop      = mem_we && mem_ready;
    assign sess_go  = (state == S_IDLE) && start;

    assign mem_wdata   = mem_we ? fifo[rptr] : '0;
    assign mem_addr    = addr_q;
    assign busy        = active;
    assign done        = (state == S_DONE);
    assign word_count  = wc;
    assign illegal_err = ill_q;

    // Encode the presented request into its 32-bit machine word.
    always_comb begin
        enc   = '0;
        legal = 1'b1;
        case (op_kind)
            K_ADD:   enc = {6'b000000, rs, rt, rd, 5'b0, 6'b100000};
            K_SUB:   enc = {6'b000000, rs, rt, rd, 5'b0, 6'b100010};
            K_AND:   enc = {6'b000000, rs, rt, rd, 5'b0, 6'b100100};
            K_OR:    enc = {6'b000000, rs, rt, rd, 5'b0, 6'b100101};
            K_SLT:   enc = {6'b000000, rs, rt, rd, 5'b0, 6'b101010};
            K_LW:    enc = {6'b100011, rs, rt, imm};
            K_SW:    enc = {6'b101011, rs, rt, imm};
            K_J:     enc = {6'b000010, target};
            K_BEQ:   enc = {6'b000100, rs, rt, imm};
            K_BNE:   enc = {6'b000101, rs, rt, imm};
            K_NOP:   enc = '0;
            default: legal = 1'b0;
        endcase
    end

    // Session FSM: idle, accept ops, drain the FIFO, pulse done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (start) state <= S_LOAD;
                S_LOAD:  if (finish) state <= S_DRAIN;
                S_DRAIN: if (cnt == '0) state <= S_DONE;
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Per-session address, counters and sticky illegal flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_lat <= '0;
            addr_q   <= '0;
            acc      <= '0;
            wc       <= '0;
            ill_q    <= 1'b0;
        end else if (sess_go) begin
            base_lat <= base_addr;
            addr_q   <= base_addr;
            acc      <= '0;
            wc       <= '0;
            ill_q    <= 1'b0;
        end else begin
            if (push) acc <= acc + 1'b1;
            if (accept && !legal) ill_q <= 1'b1;
            if (pop) begin
                wc <= wc + 1'b1;
                // Hold at the top address instead of wrapping to zero.
                if (addr_q != '1) addr_q <= addr_q + 1'b1;
            end
        end
    end

    // FIFO pointers and occupancy; emptied at session start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else if (sess_go) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // FIFO storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push) fifo[wptr] <= enc;
    end

endmodule

// File: tb/tb_instr_encode_loader.sv
// Testbench for instr_encode_loader.
// Directed test-plan cases plus randomized sessions against a queue model.
module tb_instr_encode_loader;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 8;

    localparam int P_IDLE  = 0;
    localparam int P_LOAD  = 1;
    localparam int P_DRAIN = 2;
    localparam int P_DONE  = 3;

    localparam logic [5:0] FN [5] = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42};
    localparam logic [5:0] OPC [11] = '{6'd0, 6'd0, 6'd0, 6'd0, 6'd0,
                                        6'd35, 6'd43, 6'd2, 6'd4, 6'd5,
                                        6'd0};

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic              finish = 1'b0;
    logic              op_valid = 1'b0;
    logic              op_ready;
    logic [3:0]        op_kind = '0;
    logic [4:0]        rs = '0;
    logic [4:0]        rt = '0;
    logic [4:0]        rd = '0;
    logic [15:0]       imm = '0;
    logic [25:0]       target = '0;
    logic              mem_we;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              busy;
    logic              done;
    logic [ADDR_W:0]   word_count;
    logic              illegal_err;

    logic rnd_rdy = 1'b0;
    logic fix_rdy = 1'b1;
    logic rnd_bit = 1'b1;
    assign mem_ready = rnd_rdy ? rnd_bit : fix_rdy;

    instr_encode_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .finish(finish), .op_valid(op_valid), .op_ready(op_ready),
        .op_kind(op_kind), .rs(rs), .rt(rt), .rd(rd), .imm(imm),
        .target(target), .mem_we(mem_we), .mem_ready(mem_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy),
        .done(done), .word_count(word_count), .illegal_err(illegal_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        rnd_bit = ($urandom_range(0, 3) != 0);
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_enc(input int k,
        input logic [4:0] s, input logic [4:0] t, input logic [4:0] d,
        input logic [15:0] im, input logic [25:0] tg);
        if (k < 5) return {6'd0, s, t, d, 5'd0, FN[k]};
        if (k == 7) return {OPC[k], tg};
        if (k == 10) return 32'd0;
        return {OPC[k], s, t, im};
    endfunction

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [31:0]       w;
    } wr_t;

    wr_t mq[$];
    wr_t wlog[$];
    int  m_ph = P_IDLE;
    int  ph0;
    int  m_base = 0;
    int  m_acc = 0;
    int  m_wc = 0;
    bit  m_ill = 1'b0;
    bit  act, erdy, ewe;

    // Reference model: predict outputs, then advance on the coming edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            m_ph = P_IDLE;
            mq.delete();
            m_base = 0;
            m_acc = 0;
            m_wc = 0;
            m_ill = 1'b0;
        end else begin
            act  = (m_ph == P_LOAD) || (m_ph == P_DRAIN);
            ewe  = act && (mq.size() > 0);
            erdy = (m_ph == P_LOAD) && (mq.size() < DEPTH) &&
                   (m_acc < (1 << ADDR_W) - m_base);
            chk("busy", busy, act);
            chk("done", done, m_ph == P_DONE);
            chk("op_ready", op_ready, erdy);
            chk("mem_we", mem_we, ewe);
            chk("word_count", word_count, m_wc);
            chk("illegal_err", illegal_err, m_ill);
            if (ewe && mem_we) begin
                chk("mem_addr", mem_addr, mq[0].a);
                chk("mem_wdata", mem_wdata, mq[0].w);
            end
            if (mem_we && mem_ready) wlog.push_back('{a: mem_addr, w: mem_wdata});
            ph0 = m_ph;
            if (ph0 == P_IDLE) begin
                if (start) begin
                    m_ph = P_LOAD;
                    m_base = int'(base_addr);
                    m_acc = 0;
                    m_wc = 0;
                    m_ill = 1'b0;
                end
            end else if (ph0 == P_DONE) begin
                m_ph = P_IDLE;
            end else begin
                if (ewe && mem_ready) begin
                    void'(mq.pop_front());
                    m_wc++;
                end
                if (ph0 == P_LOAD) begin
                    if (op_valid && erdy) begin
                        if (op_kind > 4'd10) begin
                            m_ill = 1'b1;
                        end else begin
                            mq.push_back('{a: ADDR_W'(m_base + m_acc),
                                w: ref_enc(int'(op_kind), rs, rt, rd, imm, target)});
                            m_acc++;
                        end
                    end
                    if (finish) m_ph = P_DRAIN;
                end else if (!ewe) begin
                    m_ph = P_DONE;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int k, input logic [4:0] s, input logic [4:0] t,
                        input logic [4:0] d, input logic [15:0] im,
                        input logic [25:0] tg, input int bound, output bit ok);
        op_kind = 4'(k);
        rs = s;
        rt = t;
        rd = d;
        imm = im;
        target = tg;
        op_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < bound && !ok; i++) begin
            if (op_ready) ok = 1'b1;
            tick();
        end
        op_valid = 1'b0;
    endtask

    task automatic sess_start(input logic [ADDR_W-1:0] b);
        base_addr = b;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic sess_finish();
        finish = 1'b1;
        tick();
        finish = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            if (done) seen = 1'b1;
            else tick();
        end
        chk(tag, seen, 1'b1);
        tick();
    endtask

    task automatic chk_log(input string tag, input int idx,
                           input logic [ADDR_W-1:0] a, input logic [31:0] w);
        if (idx < wlog.size()) begin
            chk({tag, "_addr"}, wlog[idx].a, a);
            chk({tag, "_data"}, wlog[idx].w, w);
        end else begin
            chk({tag, "_missing"}, 1'b0, 1'b1);
        end
    endtask

    bit ok, ok2, ok3;
    int n_ops;

    initial begin
        #5000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_op_ready", op_ready, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_addr", mem_addr, '0);
        chk("rst_mem_wdata", mem_wdata, '0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_word_count", word_count, '0);
        chk("rst_illegal", illegal_err, 1'b0);
        rst_n = 1'b1;
        tick();

        // R-type and LW encodings
        wlog.delete();
        sess_start(8'h10);
        send(0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 20, ok);
        send(1, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 20, ok);
        send(5, 5'd29, 5'd8, 5'd0, 16'h4, 26'h0, 20, ok);
        sess_finish();
        wait_done("t1_done");
        chk("t1_count", word_count, 3);
        chk_log("t1_add", 0, 8'h10, 32'h00221820);
        chk_log("t1_sub", 1, 8'h11, 32'h00221822);
        chk_log("t1_lw", 2, 8'h12, 32'h8FA80004);

        // J, BEQ, NOP encodings
        wlog.delete();
        sess_start(8'h40);
        send(7, 5'd0, 5'd0, 5'd0, 16'h0, 26'h10, 20, ok);
        send(8, 5'd1, 5'd2, 5'd0, 16'hFFFF, 26'h0, 20, ok);
        send(10, 5'd7, 5'd7, 5'd7, 16'h1234, 26'h0, 20, ok);
        sess_finish();
        wait_done("t2_done");
        chk_log("t2_j", 0, 8'h40, 32'h08000010);
        chk_log("t2_beq", 1, 8'h41, 32'h1022FFFF);
        chk_log("t2_nop", 2, 8'h42, 32'h00000000);

        // Backpressure with a full FIFO
        wlog.delete();
        fix_rdy = 1'b0;
        sess_start(8'h20);
        for (int i = 0; i < DEPTH; i++) begin
            send(0, 5'd1, 5'd2, 5'(3 + i), 16'h0, 26'h0, 20, ok);
            chk("t3_accept", ok, 1'b1);
        end
        chk("t3_full_rdy", op_ready, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("t3_hold_we", mem_we, 1'b1);
            chk("t3_hold_addr", mem_addr, 8'h20);
            chk("t3_hold_data", mem_wdata, 32'h00221820);
            tick();
        end
        send(0, 5'd1, 5'd2, 5'd9, 16'h0, 26'h0, 3, ok);
        chk("t3_no_accept", ok, 1'b0);
        fix_rdy = 1'b1;
        sess_finish();
        wait_done("t3_done");
        chk("t3_count", word_count, 4);
        for (int i = 0; i < DEPTH; i++)
            chk_log("t3_wr", i, 8'(8'h20 + i),
                    ref_enc(0, 5'd1, 5'd2, 5'(3 + i), 16'h0, 26'h0));

        // Illegal kind
        wlog.delete();
        sess_start(8'h30);
        send(0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 20, ok);
        send(13, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 20, ok2);
        chk("t4_ill_accept", ok2, 1'b1);
        send(0, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0, 20, ok);
        sess_finish();
        wait_done("t4_done");
        chk("t4_sticky", illegal_err, 1'b1);
        chk("t4_count", word_count, 2);
        chk("t4_written", wlog.size(), 2);
        sess_start(8'h00);
        chk("t4_clear", illegal_err, 1'b0);
        sess_finish();
        wait_done("t4_done2");

        // Address limit
        wlog.delete();
        sess_start(8'hFE);
        send(0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 10, ok);
        send(1, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 10, ok2);
        send(2, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 10, ok3);
        chk("t5_ok1", ok, 1'b1);
        chk("t5_ok2", ok2, 1'b1);
        chk("t5_ok3", ok3, 1'b0);
        chk("t5_rdy", op_ready, 1'b0);
        sess_finish();
        wait_done("t5_done");
        chk("t5_count", word_count, 2);
        chk_log("t5_w0", 0, 8'hFE, 32'h00221820);
        chk_log("t5_w1", 1, 8'hFF, 32'h00221822);

        // Reset mid-drain
        wlog.delete();
        fix_rdy = 1'b0;
        sess_start(8'h50);
        send(3, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 20, ok);
        send(4, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 20, ok);
        sess_finish();
        tick();
        chk("t6_drain_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("t6_op_ready", op_ready, 1'b0);
        chk("t6_mem_we", mem_we, 1'b0);
        chk("t6_mem_addr", mem_addr, '0);
        chk("t6_mem_wdata", mem_wdata, '0);
        chk("t6_busy", busy, 1'b0);
        chk("t6_done", done, 1'b0);
        chk("t6_word_count", word_count, '0);
        chk("t6_illegal", illegal_err, 1'b0);
        fix_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6_no_done", done, 1'b0);
        end
        rst_n = 1'b1;
        tick();
        wlog.delete();
        sess_start(8'h60);
        send(0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 20, ok);
        sess_finish();
        wait_done("t6_done");
        chk("t6_count", word_count, 1);
        chk_log("t6_w0", 0, 8'h60, 32'h00221820);

        // Randomized sessions, checked by the model every cycle
        rnd_rdy = 1'b1;
        for (int s = 0; s < 12; s++) begin
            if (s % 3 == 0) sess_start(8'(256 - $urandom_range(1, 6)));
            else sess_start(8'($urandom_range(0, 255)));
            n_ops = $urandom_range(0, 12);
            for (int i = 0; i < n_ops; i++) begin
                send(($urandom_range(0, 7) == 0) ? $urandom_range(11, 15)
                                                  : $urandom_range(0, 10),
                     5'($urandom), 5'($urandom), 5'($urandom),
                     16'($urandom), 26'($urandom), 8, ok);
                repeat ($urandom_range(0, 2)) tick();
            end
            sess_finish();
            wait_done("rnd_done");
        end
        rnd_rdy = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/instr_encode_loader.md
Name: instr_encode_loader

Overview:
- Encodes symbolic instruction requests (ADD/SUB/AND/OR/SLT/LW/SW/J/BEQ/BNE/NOP) into 32-bit MIPS words.
- Buffers the encoded words in a small FIFO.
- Writes them sequentially into instruction memory from a programmable base address.
- It is the encoding end of the opcode/func field format that the pipeline control unit decodes, and it is used to load programs before or between runs.

Parameters:
- DEPTH, 4, encoded-word FIFO entries (power of two, ≥2)
- ADDR_W, 8, instruction-memory word-address width

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  pulse; begins a load session (IDLE only)
- base_addr  input  ADDR_W  first word address; sampled on start
- finish  input  1  pulse; no more ops, drain and complete
- op_valid  input  1  request valid
- op_ready  output  1  request accepted when op_valid&&op_ready
- op_kind  input  4  0 ADD,1 SUB,2 AND,3 OR,4 SLT,5 LW,6 SW,7 J,8 BEQ,9 BNE,10 NOP; 11-15 illegal
- rs, rt, rd  input  5 each  register fields
- imm  input  16  immediate/offset (LW/SW/BEQ/BNE)
- target  input  26  jump target (J)
- mem_we  output  1  write request to instruction memory
- mem_ready  input  1  memory accepts write when mem_we&&mem_ready
- mem_addr  output  ADDR_W  write word address
- mem_wdata  output  32  encoded word
- busy  output  1  high in LOAD or DRAIN
- done  output  1  one-cycle pulse at session end
- word_count  output  ADDR_W+1  words written this session
- illegal_err  output  1  sticky; illegal op_kind accepted this session

Behaviour:
- Reset (async, rst_n=0):
  - FSM goes to IDLE and the FIFO is emptied.
  - op_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, word_count=0, illegal_err=0.
  - Asserting reset mid-session abandons the session; no done pulse is produced.
- Encoding:
  - R-type (kinds 0-4): {6'b000000, rs, rt, rd, 5'b0, func}. func is ADD 100000, SUB 100010, AND 100100, OR 100101, SLT 101010.
  - LW: {100011, rs, rt, imm}.
  - SW: {101011, rs, rt, imm}.
  - BEQ: {000100, rs, rt, imm}.
  - BNE: {000101, rs, rt, imm}.
  - J: {000010, target}.
  - NOP: 32'h00000000.
  - Unused fields are ignored.
  - An illegal kind is accepted, not enqueued, and sets illegal_err.
- FSM states:
  - IDLE: op_ready=0. start → LOAD. Entering LOAD latches base_addr into mem_addr and clears word_count and illegal_err.
  - LOAD:
    - op_ready = !fifo_full && (accepted_words < 2^ADDR_W - base_latched).
    - The address limit is reached → op_ready stays 0; addresses never wrap.
    - finish → DRAIN. An op accepted in the same cycle as finish is kept.
  - DRAIN: op_ready=0. When the FIFO is empty and no write is pending → DONE.
  - DONE: done=1 for one cycle, busy=0, → IDLE.
- start outside IDLE is ignored; finish outside LOAD is ignored.
- FIFO and write timing:
  - The word is encoded at acceptance and written into the FIFO on that edge.
  - mem_we = FIFO non-empty in LOAD or DRAIN, and mem_wdata = FIFO head.
  - Earliest mem_we is the cycle after acceptance (latency 1).
  - On mem_we&&mem_ready: pop, mem_addr+1, word_count+1.
  - While mem_ready=0, mem_we, mem_addr and mem_wdata hold stable.
- Push and pop in the same cycle are both allowed; occupancy is unchanged. op_ready depends only on the registered full flag, not on a same-cycle pop.
- Full: op_ready=0 until a pop occurs. Empty: mem_we=0.

Test Plan:
- Encoding, R-type and LW:
  - start base=0x10, then ADD rd=3 rs=1 rt=2 → mem_addr 0x10, mem_wdata 32'h00221820.
  - Then SUB with the same fields → 0x11, 32'h00221822.
  - Then LW rt=8 rs=29 imm=4 → 0x12, 32'h8FA80004.
  - Then finish → done pulse, word_count=3.
- Encoding, J and BEQ:
  - J target=26'h10 → 32'h08000010.
  - BEQ rs=1 rt=2 imm=16'hFFFF → 32'h1022FFFF.
  - NOP → 32'h00000000.
- Backpressure:
  - Hold mem_ready=0 while pushing DEPTH=4 ops → op_ready drops after the 4th; mem_we, mem_addr and mem_wdata stay stable.
  - Release mem_ready → 4 consecutive writes, addresses incrementing.
- Illegal kind:
  - op_kind=13 between two ADDs → illegal_err=1 (sticky), only 2 words written, word_count=2.
  - The next start clears illegal_err.
- Address limit:
  - ADDR_W=8, base=0xFE: push 3 ops → only 2 accepted, written at 0xFE and 0xFF; op_ready stays 0; finish → done.
- Reset mid-session:
  - rst_n low in DRAIN with 2 words queued → all outputs 0 immediately and no done pulse.
  - After reset a new start works normally.
